// File: rtl/atm_bank_arbiter.sv
// Shared-account transaction arbiter: round-robin grant among ATM terminals,
// then a serialized read-modify-write of one balance word per transaction.
module atm_bank_arbiter #(
  parameter int NUM_TERM = 4,
  parameter int NUM_ACC  = 10,
  parameter int ACC_W    = 4,
  parameter int BAL_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TERM-1:0]       req,
  input  logic [2*NUM_TERM-1:0]     op,
  input  logic [ACC_W*NUM_TERM-1:0] acc,
  input  logic [BAL_W*NUM_TERM-1:0] amount,
  output logic [NUM_TERM-1:0]       grant,
  output logic [NUM_TERM-1:0]       done,
  output logic                      success,
  output logic [1:0]                status,
  output logic [BAL_W-1:0]          resp_balance,
  output logic                      busy
);

  localparam int PTR_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NSF     = 2'b01,
    ST_BAD_ACC = 2'b10,
    ST_BAD_OP  = 2'b11
  } status_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;

  logic [1:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [BAL_W-1:0] amt_q;
  logic [BAL_W-1:0] rd;
  logic [BAL_W-1:0] new_bal;
  logic             wr_en;
  logic             res_ok;
  status_t          res_status;
  logic [BAL_W-1:0] res_bal;

  logic [BAL_W-1:0] mem [NUM_ACC];

  // Round-robin pick
  logic [NUM_TERM-1:0] eligible;
  logic [PTR_W-1:0]    pick;
  logic                pick_found;
  int                  scan;

  // A terminal whose done pulse is on the wire drops req at this same edge;
  // masking it keeps it from being served twice.
  assign eligible = req & ~done;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan       = 0;
    // Scan from farthest to nearest so the entry closest to ptr wins last.
    for (int k = NUM_TERM - 1; k >= 0; k--) begin
      scan = int'((32'(ptr) + 32'(k)) % 32'(NUM_TERM));
      if (eligible[scan[PTR_W-1:0]]) begin
        pick       = scan[PTR_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Transaction evaluation
  logic             acc_ok;
  logic [BAL_W:0]   sum;
  logic             x_ok;
  logic             x_wr;
  status_t          x_status;
  logic [BAL_W-1:0] x_bal;
  logic [BAL_W-1:0] x_new;

  assign acc_ok = 32'(acc_q) < 32'(NUM_ACC);
  assign sum    = {1'b0, rd} + {1'b0, amt_q};

  always_comb begin
    x_ok     = 1'b0;
    x_wr     = 1'b0;
    x_status = ST_BAD_OP;
    x_bal    = rd;
    x_new    = rd;
    if (!acc_ok) begin
      x_status = ST_BAD_ACC;
      x_bal    = '0;
    end else begin
      case (op_q)
        OP_BAL: begin
          x_ok     = 1'b1;
          x_status = ST_OK;
        end
        OP_WD: begin
          if (amt_q <= rd) begin
            x_ok     = 1'b1;
            x_wr     = 1'b1;
            x_status = ST_OK;
            x_new    = rd - amt_q;
            x_bal    = rd - amt_q;
          end else begin
            x_status = ST_NSF;
          end
        end
        OP_DEP: begin
          // A carry out of the balance width is reported like a bad opcode.
          if (!sum[BAL_W]) begin
            x_ok     = 1'b1;
            x_wr     = 1'b1;
            x_status = ST_OK;
            x_new    = sum[BAL_W-1:0];
            x_bal    = sum[BAL_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM, datapath registers and balance store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      winner       <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      amt_q        <= '0;
      rd           <= '0;
      new_bal      <= '0;
      wr_en        <= 1'b0;
      res_ok       <= 1'b0;
      res_status   <= ST_OK;
      res_bal      <= '0;
      grant        <= '0;
      done         <= '0;
      success      <= 1'b0;
      status       <= 2'b00;
      resp_balance <= '0;
      busy         <= 1'b0;
      // NOTE: the store is small and must come up with known opening balances,
      // so it is built from flops with reset rather than a RAM macro.
      for (int i = 0; i < NUM_ACC; i++) begin
        mem[i] <= BAL_W'(1000 * (i + 1));
      end
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            winner       <= pick;
            op_q         <= op[2*pick +: 2];
            acc_q        <= acc[ACC_W*pick +: ACC_W];
            amt_q        <= amount[BAL_W*pick +: BAL_W];
            grant        <= '0;
            grant[pick]  <= 1'b1;
            busy         <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          rd    <= acc_ok ? mem[acc_q] : '0;
          state <= EXEC;
        end
        EXEC: begin
          res_ok     <= x_ok;
          res_status <= x_status;
          res_bal    <= x_bal;
          new_bal    <= x_new;
          wr_en      <= x_wr;
          state      <= WRITE;
        end
        WRITE: begin
          if (wr_en) begin
            mem[acc_q] <= new_bal;
          end
          done[winner] <= 1'b1;
          success      <= res_ok;
          status       <= res_status;
          resp_balance <= res_bal;
          ptr          <= (winner == PTR_W'(NUM_TERM - 1)) ? '0 : winner + PTR_W'(1);
          grant        <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_arbiter.sv
// Scoreboard bench for atm_bank_arbiter: directed and random request batches
// checked against a round-robin/account model kept in plain arithmetic.
module tb_atm_bank_arbiter;

  localparam int NT = 4;
  localparam int NA = 10;
  localparam int AW = 4;
  localparam int BW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NT-1:0]     req;
  logic [2*NT-1:0]   op;
  logic [AW*NT-1:0]  acc;
  logic [BW*NT-1:0]  amount;
  logic [NT-1:0]     grant;
  logic [NT-1:0]     done;
  logic              success;
  logic [1:0]        status;
  logic [BW-1:0]     resp_balance;
  logic              busy;

  atm_bank_arbiter #(.NUM_TERM(NT), .NUM_ACC(NA), .ACC_W(AW), .BAL_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .op           (op),
    .acc          (acc),
    .amount       (amount),
    .grant        (grant),
    .done         (done),
    .success      (success),
    .status       (status),
    .resp_balance (resp_balance),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        term;
    bit        ok;
    bit [1:0]  st;
    bit [31:0] bal;
  } exp_t;

  exp_t            sbq[$];
  int              vectors     = 0;
  int              miscompares = 0;
  longint unsigned mdl_mem[NA];
  int              mdl_ptr;

  int              s_op [NT];
  int              s_acc[NT];
  logic [BW-1:0]   s_amt[NT];

  logic            last_ok;
  logic [1:0]      last_st;
  logic [BW-1:0]   last_bal;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) mdl_mem[i] = 64'(1000 * (i + 1));
    mdl_ptr = 0;
  endtask

  // Account semantics straight from the opcode rules.
  function automatic exp_t model(input int term, input int o, input int a, input longint unsigned amt);
    exp_t e;
    longint unsigned bal;
    e.term = term;
    e.ok   = 1'b0;
    e.st   = 2'd3;
    if (a >= NA) begin
      e.st  = 2'd2;
      e.bal = 32'd0;
      return e;
    end
    bal   = mdl_mem[a];
    e.bal = 32'(bal);
    case (o)
      0: begin e.ok = 1'b1; e.st = 2'd0; end
      1: begin
        if (amt <= bal) begin
          mdl_mem[a] = bal - amt;
          e.ok = 1'b1; e.st = 2'd0; e.bal = 32'(mdl_mem[a]);
        end else begin
          e.st = 2'd1;
        end
      end
      2: begin
        if (bal + amt < 64'h1_0000_0000) begin
          mdl_mem[a] = bal + amt;
          e.ok = 1'b1; e.st = 2'd0; e.bal = 32'(mdl_mem[a]);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic set_term(input int t, input int o, input int a, input logic [BW-1:0] amt);
    s_op[t]  = o;
    s_acc[t] = a;
    s_amt[t] = amt;
  endtask

  // Raise all requests in mask together; the model orders them round-robin.
  task automatic issue(input logic [NT-1:0] mask, input bit use_model);
    int            p;
    int            w;
    logic [NT-1:0] pend;
    @(negedge clk);
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        op[2*i +: 2]     = 2'(s_op[i]);
        acc[AW*i +: AW]  = AW'(s_acc[i]);
        amount[BW*i +: BW] = s_amt[i];
      end
    end
    req = mask;
    if (use_model) begin
      p    = mdl_ptr;
      pend = mask;
      while (pend != '0) begin
        w = -1;
        for (int k = 0; k < NT; k++) begin
          if (w < 0 && pend[(p + k) % NT]) w = (p + k) % NT;
        end
        sbq.push_back(model(w, s_op[w], s_acc[w], 64'(s_amt[w])));
        pend[w] = 1'b0;
        p = (w + 1) % NT;
      end
      mdl_ptr = p;
    end
  endtask

  task automatic wait_batch();
    for (int c = 0; c < 200 && sbq.size() != 0; c++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("batch_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
      req = '0;
    end
  endtask

  // Monitor: pops one expectation per done pulse; tracks grant ownership.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (busy && sbq.size() != 0) begin
          check("grant_owner", 64'(grant), 64'(1 << sbq[0].term));
        end
        if (done !== '0) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            e = sbq.pop_front();
            check("done_term", 64'(done), 64'(1 << e.term));
            check("success", 64'(success), 64'(e.ok));
            check("status", 64'(status), 64'(e.st));
            check("resp_balance", 64'(resp_balance), 64'(e.bal));
            check("grant_at_done", 64'(grant), 64'd0);
            check("busy_at_done", 64'(busy), 64'd0);
          end
          last_ok  = success;
          last_st  = status;
          last_bal = resp_balance;
          req      = req & ~done;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int            kind;
    logic [NT-1:0] mask;
    rst    = 1'b0;
    req    = '0;
    op     = '0;
    acc    = '0;
    amount = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_success", 64'(success), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_resp", 64'(resp_balance), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Balance of acc 3 with cycle-exact timing.
    set_term(0, 0, 3, 32'd0);
    issue(4'b0001, 1'b1);
    @(posedge clk); #1;
    check("lat_grant_e0", 64'(grant), 64'b0001);
    check("lat_busy_e0", 64'(busy), 64'd1);
    repeat (2) @(posedge clk); #1;
    check("lat_no_done_e2", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("lat_done_e3", 64'(done), 64'b0001);
    wait_batch();
    check("t_bal3", 64'(last_bal), 64'd4000);

    // Withdraw then re-read on the same account.
    set_term(1, 1, 0, 32'd500);  issue(4'b0010, 1'b1); wait_batch();
    check("t_wd500", 64'(last_bal), 64'd500);
    set_term(1, 0, 0, 32'd0);    issue(4'b0010, 1'b1); wait_batch();
    check("t_rd_after_wd", 64'(last_bal), 64'd500);

    // Insufficient funds, then exact-balance withdraw.
    set_term(2, 1, 2, 32'd3001); issue(4'b0100, 1'b1); wait_batch();
    check("t_nsf_status", 64'(last_st), 64'd1);
    set_term(2, 1, 2, 32'd3000); issue(4'b0100, 1'b1); wait_batch();
    check("t_exact_wd", 64'(last_bal), 64'd0);

    // Overflow, bad account, reserved opcode, zero amounts.
    set_term(3, 2, 9, 32'hFFFF_F000); issue(4'b1000, 1'b1); wait_batch();
    check("t_ovf_status", 64'(last_st), 64'd3);
    set_term(0, 0, 12, 32'd0);        issue(4'b0001, 1'b1); wait_batch();
    check("t_badacc_status", 64'(last_st), 64'd2);
    set_term(1, 3, 4, 32'd7);         issue(4'b0010, 1'b1); wait_batch();
    set_term(2, 1, 6, 32'd0);         issue(4'b0100, 1'b1); wait_batch();
    set_term(3, 2, 6, 32'd0);         issue(4'b1000, 1'b1); wait_batch();
    check("t_zero_amt", 64'(last_bal), 64'd7000);

    // Full contention on one account, twice, to show the pointer wraps to 0.
    for (int i = 0; i < NT; i++) set_term(i, 2, 5, 32'd100);
    issue(4'b1111, 1'b1); wait_batch();
    check("t_contend_final", 64'(last_bal), 64'd6400);
    for (int i = 0; i < NT; i++) set_term(i, 0, 5, 32'd0);
    issue(4'b1111, 1'b1); wait_batch();

    // Random batches.
    for (int n = 0; n < 150; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NT; i++) begin
        s_op[i]  = $urandom_range(0, 3);
        s_acc[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 9) : $urandom_range(0, 15);
        kind     = $urandom_range(0, 5);
        if (kind == 0)                     s_amt[i] = '0;
        else if (kind == 1 && s_acc[i] < NA) s_amt[i] = 32'(mdl_mem[s_acc[i]]);
        else if (kind == 2)                s_amt[i] = $urandom;
        else                               s_amt[i] = 32'($urandom_range(0, 5000));
      end
      issue(mask, 1'b1);
      wait_batch();
    end

    // Reset while a withdraw of 100 from acc 1 is in EXEC.
    set_term(0, 1, 1, 32'd100);
    issue(4'b0001, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_grant", 64'(grant), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_success", 64'(success), 64'd0);
    check("abort_status", 64'(status), 64'd0);
    check("abort_resp", 64'(resp_balance), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_term(0, 0, 1, 32'd0); issue(4'b0001, 1'b1); wait_batch();
    check("abort_no_write", 64'(last_bal), 64'd2000);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
